// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS-style core: opcodes, instruction
// field positions, reset PC and the fetch FSM state type.
package mips_pkg;

  localparam logic [15:0] RESET_PC = 16'h0000;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_ADDI  = 3'd1;
  localparam logic [2:0] OP_LW    = 3'd2;
  localparam logic [2:0] OP_SW    = 3'd3;
  localparam logic [2:0] OP_BEQ   = 3'd4;
  localparam logic [2:0] OP_J     = 3'd5;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 13;
  localparam int RS_MSB    = 12;
  localparam int RS_LSB    = 10;
  localparam int RT_MSB    = 9;
  localparam int RT_LSB    = 7;
  localparam int RD_MSB    = 6;
  localparam int RD_LSB    = 4;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;
  localparam int IMM7_MSB  = 6;
  localparam int IMM7_LSB  = 0;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction word and its fetch PC that
// arrives while the IF/ID register is stalled.
module fetch_skid_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              release_entry,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] pc
);

  // Clear beats capture so a flush can never leave a wrong-path word behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= data_in;
      pc    <= pc_in;
    end else if (release_entry) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch and IF/ID register: owns the PC, issues requests to the
// 1-cycle instruction memory, absorbs stalls via a skid entry, squashes on flush.
module fetch_decode_stage #(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc_plus1,
  output logic [2:0]        id_opcode,
  output logic [2:0]        id_rs,
  output logic [2:0]        id_rt,
  output logic [2:0]        id_rd,
  output logic [3:0]        id_funct,
  output logic [6:0]        id_imm7
);

  import mips_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              skid_valid;
  logic [15:0]       skid_data;
  logic [ADDR_W-1:0] skid_pc;
  logic [15:0]       load_instr;
  logic [ADDR_W-1:0] load_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:         state_d = ST_RUN;
      ST_RUN, ST_HOLD: state_d = (!flush && stall) ? ST_HOLD : ST_RUN;
      default:         state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    imem_req  = (state_q != ST_BOOT) && !stall && !flush;
    imem_addr = pc_q;
  end

  // The PC only advances when a request actually goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      if (flush)         pc_q <= branch_target;
      else if (imem_req) pc_q <= pc_q + ADDR_W'(1);
      inflight_q <= imem_req;
      if (imem_req) inflight_pc_q <= pc_q;
    end
  end

  fetch_skid_buffer #(.DATA_W(16), .ADDR_W(ADDR_W)) u_skid (
    .clk           (clk),
    .rst_n         (rst_n),
    .capture       (inflight_q && stall && !flush),
    .release_entry (skid_valid && !stall && !flush),
    .clear         (flush),
    .data_in       (imem_rdata),
    .pc_in         (inflight_pc_q),
    .valid         (skid_valid),
    .data          (skid_data),
    .pc            (skid_pc)
  );

  // A parked skid word is always older than any fresh response.
  always_comb begin
    load_instr = skid_valid ? skid_data : imem_rdata;
    load_pc    = skid_valid ? skid_pc   : inflight_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_pc_plus1 <= '0;
      id_opcode   <= '0;
      id_rs       <= '0;
      id_rt       <= '0;
      id_rd       <= '0;
      id_funct    <= '0;
      id_imm7     <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (!stall) begin
      if (skid_valid || inflight_q) begin
        id_valid    <= 1'b1;
        id_pc_plus1 <= load_pc + ADDR_W'(1);
        id_opcode   <= load_instr[OPC_MSB:OPC_LSB];
        id_rs       <= load_instr[RS_MSB:RS_LSB];
        id_rt       <= load_instr[RT_MSB:RT_LSB];
        id_rd       <= load_instr[RD_MSB:RD_LSB];
        id_funct    <= load_instr[FUNCT_MSB:FUNCT_LSB];
        id_imm7     <= load_instr[IMM7_MSB:IMM7_LSB];
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule
